// File: rtl/key_mode_conditioner_pkg.sv
// Shared mode encodings for the KEY front-end and the LED pattern stage.
// Also holds the press-to-mode priority resolver.
package key_mode_conditioner_pkg;

    localparam logic [2:0] MODE_HOLD    = 3'd0;
    localparam logic [2:0] MODE_FWD     = 3'd1;
    localparam logic [2:0] MODE_REV     = 3'd2;
    localparam logic [2:0] MODE_ALL_ON  = 3'd3;
    localparam logic [2:0] MODE_ALL_OFF = 3'd4;

    // Highest-numbered key wins when several presses land in the same cycle
    function automatic logic [2:0] resolve_mode(input logic [3:0] press,
                                                input logic [2:0] cur);
        logic [2:0] m;
        m = cur;
        if (press[3])      m = MODE_FWD;
        else if (press[2]) m = MODE_ALL_ON;
        else if (press[1]) m = MODE_ALL_OFF;
        else if (press[0]) m = MODE_REV;
        return m;
    endfunction

endpackage

// File: rtl/key_mode_conditioner_debounce.sv
// One pushbutton: two-flop synchroniser, debounce counter and press-edge pulse.
// A key held through reset must be seen released before it can produce a press.
module key_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          key_p0;
    logic          key_p1;
    logic          sync;
    logic [1:0]    fill;
    logic          armed;
    logic          level_d;
    logic [CW-1:0] cnt;

    assign sync = ~key_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_p0  <= 1'b1;
            key_p1  <= 1'b1;
            fill    <= '0;
            armed   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            key_p0 <= key_n;
            key_p1 <= key_p0;
            // fill[1] marks that the synchroniser now carries real samples, not reset values
            fill   <= {fill[0], 1'b1};
            if (fill[1] && !sync)
                armed <= 1'b1;

            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            level_d <= level;
            press   <= level & ~level_d & armed;
        end
    end

endmodule

// File: rtl/key_mode_conditioner.sv
// KEY[3:0] front-end: debounced levels, press pulses, registered display mode
// and a step-rate tick that restarts on every mode change.
module key_mode_conditioner
    import key_mode_conditioner_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int TICK_HZ     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [2:0] mode,
    output logic       mode_change,
    output logic       tick
);

    localparam int DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int TICK_CYCLES = CLK_HZ / TICK_HZ;
    localparam int TW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

    logic          press_any;
    logic [TW-1:0] tick_cnt;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_key (
            .clk   (clk),
            .rst_n (rst_n),
            .key_n (key_n[i]),
            .level (key_level[i]),
            .press (key_press[i])
        );
    end

    assign press_any = |key_press;

    // Re-pressing the current mode's key still pulses mode_change to restart the pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode        <= MODE_HOLD;
            mode_change <= 1'b0;
        end else begin
            mode_change <= press_any;
            if (press_any)
                mode <= resolve_mode(key_press, mode);
        end
    end

    // Cleared in the same edge that raises mode_change, so the next tick is TICK_CYCLES later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (press_any) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == TICK_MAX) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            tick     <= 1'b0;
        end
    end

endmodule
